// File: rtl/truth_table_scanner_pkg.sv
// Shared FSM encoding, default parameter values and sizing helper for truth_table_scanner.
package truth_table_scanner_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDrive  = 2'd1,
        StSample = 2'd2,
        StDone   = 2'd3
    } scan_state_e;

    localparam int unsigned DefaultNIn          = 3;
    localparam int unsigned DefaultSettleCycles = 2;

    // Settle counter width, never below one bit.
    function automatic int unsigned settle_width(input int unsigned cycles);
        return (cycles + 1 <= 2) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/scan_settle_timer.sv
// Settle down-counter: clear reloads CYCLES-1, enable counts toward zero, expire flags zero.
module scan_settle_timer #(
    parameter int unsigned CYCLES = 2,
    parameter int unsigned WIDTH  = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [WIDTH-1:0] Reload = WIDTH'(CYCLES - 1);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = Reload;
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Walks sel_out through every code, settles, and captures y_in into table_out.
// Optional TRUTH_SCAN_COMPARE_EN adds expected_in/pass for on-board table checking.
module truth_table_scanner
    import truth_table_scanner_pkg::*;
#(
    parameter int unsigned N_IN          = DefaultNIn,
    parameter int unsigned SETTLE_CYCLES = DefaultSettleCycles
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 y_in,
`ifdef TRUTH_SCAN_COMPARE_EN
    input  logic [2**N_IN-1:0]   expected_in,
    output logic                 pass,
`endif
    output logic [N_IN-1:0]      sel_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out
);

    localparam int unsigned      TableWidth = 2 ** N_IN;
    localparam int unsigned      CntWidth   = settle_width(SETTLE_CYCLES);
    localparam logic [N_IN-1:0]  LastSel    = '1;

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("truth_table_scanner: SETTLE_CYCLES must be within 1..255");
    end

    scan_state_e           state_q, state_d;
    logic [N_IN-1:0]       sel_q, sel_d;
    logic [TableWidth-1:0] table_q, table_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  timer_clear, timer_en, timer_expire;
    logic                  last_code;

    assign last_code = (sel_q == LastSel);

    scan_settle_timer #(
        .CYCLES (SETTLE_CYCLES),
        .WIDTH  (CntWidth)
    ) u_settle (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_en),
        .expire (timer_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StDrive;
            StDrive:  if (timer_expire) state_d = StSample;
            StSample: state_d = last_code ? StDone : StDrive;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Datapath and output next-values; busy/done are registered from the next state.
    always_comb begin
        sel_d       = sel_q;
        table_d     = table_q;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                sel_d = '0;
                if (start) begin
                    table_d     = '0;
                    timer_clear = 1'b1;
                end
            end
            StDrive: timer_en = 1'b1;
            StSample: begin
                table_d[sel_q] = y_in;
                if (!last_code) begin
                    sel_d       = sel_q + 1'b1;
                    timer_clear = 1'b1;
                end
            end
            StDone:  sel_d = '0;
            default: sel_d = '0;
        endcase
        busy_d = (state_d == StDrive) || (state_d == StSample);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q   <= '0;
            table_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            table_q <= table_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sel_out   = sel_q;
    assign table_out = table_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef TRUTH_SCAN_COMPARE_EN
    logic [TableWidth-1:0] expected_q, expected_d;
    logic                  pass_q, pass_d;

    always_comb begin
        expected_d = expected_q;
        pass_d     = pass_q;
        if (state_q == StIdle && start) begin
            expected_d = expected_in;
            pass_d     = 1'b0;
        end else if (state_q == StSample && last_code) begin
            pass_d = (table_d == expected_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            expected_q <= '0;
            pass_q     <= 1'b0;
        end else begin
            expected_q <= expected_d;
            pass_q     <= pass_d;
        end
    end

    assign pass = pass_q;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner at SETTLE_CYCLES 2 (default), 1 and 4.
module tb_truth_table_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    int         mode;
    logic       y0, y1, y4;
    logic [2:0] sel0, sel1, sel4;
    logic       busy0, busy1, busy4;
    logic       done0, done1, done4;
    logic [7:0] tab0, tab1, tab4;
    int         total = 0;
    int         bad   = 0;

`ifdef TRUTH_SCAN_COMPARE_EN
    logic [7:0] expected;
    logic       pass0, pass1, pass4;
`endif

    always #5 clk = ~clk;

    // 0 parity, 1 AND3, 2 constant 1, 3 constant 0
    always_comb begin
        case (mode)
            0:       y0 = ^sel0;
            1:       y0 = &sel0;
            2:       y0 = 1'b1;
            default: y0 = 1'b0;
        endcase
    end

    // One-cycle-late function output for the SETTLE_CYCLES=1 instance.
    always_ff @(posedge clk) y1 <= ^sel1;
    assign y4 = ^sel4;

    truth_table_scanner dut (
        .clk (clk), .reset (reset), .start (start), .y_in (y0),
`ifdef TRUTH_SCAN_COMPARE_EN
        .expected_in (expected), .pass (pass0),
`endif
        .sel_out (sel0), .busy (busy0), .done (done0), .table_out (tab0)
    );

    truth_table_scanner #(.N_IN(3), .SETTLE_CYCLES(1)) dut1 (
        .clk (clk), .reset (reset), .start (start), .y_in (y1),
`ifdef TRUTH_SCAN_COMPARE_EN
        .expected_in (expected), .pass (pass1),
`endif
        .sel_out (sel1), .busy (busy1), .done (done1), .table_out (tab1)
    );

    truth_table_scanner #(.N_IN(3), .SETTLE_CYCLES(4)) dut4 (
        .clk (clk), .reset (reset), .start (start), .y_in (y4),
`ifdef TRUTH_SCAN_COMPARE_EN
        .expected_in (expected), .pass (pass4),
`endif
        .sel_out (sel4), .busy (busy4), .done (done4), .table_out (tab4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full scan on the default instance; poke pulses start mid-scan and in the done cycle.
    task automatic scan_main(input string tag, input logic [7:0] exp_tab, input bit poke);
        int busy_n  = 0;
        int done_n  = 0;
        int done_at = 0;
        int sel_bad = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (busy0 === 1'b1) begin
                busy_n++;
                if (cyc > 24 || int'(sel0) != (cyc - 1) / 3) sel_bad++;
            end
            if (done0 === 1'b1) begin
                done_n++;
                done_at = cyc;
            end
            start = poke && (cyc == 7 || cyc == 25);
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " busy_cycles"}, busy_n, 24);
        check({tag, " done_cycle"}, done_at, 25);
        check({tag, " done_pulses"}, done_n, 1);
        check({tag, " sel_sequence_errors"}, sel_bad, 0);
        check({tag, " sel_idle"}, sel0, 3'd0);
        check({tag, " table"}, tab0, exp_tab);
    endtask

    initial begin
        bit found;
        int busy1_n, busy4_n, done1_at, done4_at;
        reset = 1'b1;
        start = 1'b0;
        mode  = 0;
`ifdef TRUTH_SCAN_COMPARE_EN
        expected = 8'h96;
`endif
        #1;
        check("reset sel", sel0, 3'd0);
        check("reset busy", busy0, 1'b0);
        check("reset done", done0, 1'b0);
        check("reset table", tab0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        mode = 0; scan_main("parity", 8'h96, 1'b0);
        mode = 1; scan_main("and3", 8'h80, 1'b0);
        mode = 2; scan_main("const1", 8'hFF, 1'b0);
        mode = 3; scan_main("const0", 8'h00, 1'b0);
        mode = 0; scan_main("parity_poke", 8'h96, 1'b1);

        // Asynchronous reset while sel_out==5 in DRIVE.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (busy0 === 1'b1 && sel0 == 3'd5) found = 1'b1;
            else @(negedge clk);
        end
        check("midreset reached sel5", found, 1'b1);
        reset = 1'b1;
        #1;
        check("midreset sel", sel0, 3'd0);
        check("midreset busy", busy0, 1'b0);
        check("midreset done", done0, 1'b0);
        check("midreset table", tab0, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        scan_main("after_reset", 8'h96, 1'b0);

        // start held high: one idle cycle between back-to-back scans.
        @(negedge clk);
        start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (done0 === 1'b1) found = 1'b1;
        end
        check("held done seen", found, 1'b1);
        @(negedge clk);
        check("held idle gap busy", busy0, 1'b0);
        @(negedge clk);
        check("held restart busy", busy0, 1'b1);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // SETTLE_CYCLES 1 (delayed y_in) and 4, started together.
        busy1_n = 0; busy4_n = 0; done1_at = 0; done4_at = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 50; cyc++) begin
            if (busy1 === 1'b1) busy1_n++;
            if (busy4 === 1'b1) busy4_n++;
            if (done1 === 1'b1) done1_at = cyc;
            if (done4 === 1'b1) done4_at = cyc;
            @(negedge clk);
        end
        check("settle1 busy_cycles", busy1_n, 16);
        check("settle1 done_cycle", done1_at, 17);
        check("settle1 table", tab1, 8'h96);
        check("settle4 busy_cycles", busy4_n, 40);
        check("settle4 done_cycle", done4_at, 41);
        check("settle4 table", tab4, 8'h96);

`ifdef TRUTH_SCAN_COMPARE_EN
        mode = 0;
        expected = 8'h96;
        scan_main("cmp_match", 8'h96, 1'b0);
        check("cmp_match pass", pass0, 1'b1);
        expected = 8'h97;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("cmp pass cleared on start", pass0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (done0 === 1'b1) found = 1'b1;
            else @(negedge clk);
        end
        check("cmp_miss done seen", found, 1'b1);
        check("cmp_miss pass", pass0, 1'b0);
        check("cmp_miss table", tab0, 8'h96);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
